// File: rtl/spinnaker_fpgas_spi_slave.sv
// SPI peek/poke slave: turns serial frames into single-cycle address/read/write strobes in the CLK_IN domain.
// Defining SPINNAKER_FPGAS_SPI_SLAVE_STATUS_EN adds a saturating frame-error counter readable over SPI.
//
// state    | meaning
// S_IDLE   | NSS high, waiting for a clean NSS fall
// S_CMD    | shifting in the 8-bit command
// S_ADDR   | shifting in the address; read strobe fires on the last bit
// S_DATA   | shifting in write data / shifting out read data
// S_IGNORE | frame finished, invalid or broken by reset; wait for NSS high
module spinnaker_fpgas_spi_slave #(
  parameter int SPI_ADDR_BITS = 32,
  parameter int VAL_BITS      = 32,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     CLK_IN,
  input  logic                     RESET_IN,
  input  logic                     SPI_NSS_IN,
  input  logic                     SPI_SCLK_IN,
  input  logic                     SPI_MOSI_IN,
  output logic                     SPI_MISO_OUT,
  output logic [SPI_ADDR_BITS-1:0] SPI_ADDR_OUT,
  output logic                     SPI_READ_OUT,
  output logic                     SPI_WRITE_OUT,
  output logic [VAL_BITS-1:0]      SPI_WRITE_DATA_OUT,
  input  logic [VAL_BITS-1:0]      SPI_READ_VALUE_IN
);

  localparam int RX_W  = (SPI_ADDR_BITS > VAL_BITS) ? SPI_ADDR_BITS : VAL_BITS;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;
  state_t state;

  logic [1:0]          nss_sync, sclk_sync, mosi_sync;
  logic                nss, sclk, mosi, nss_d, sclk_d;
  logic                sclk_rise, sclk_fall;
  logic [CNT_W-1:0]    bit_cnt;
  logic [RX_W-2:0]     rx_sr;
  logic [RX_W-1:0]     rx_next;
  logic [VAL_BITS-1:0] tx_sr;
  logic                is_read, is_write;
  logic                read_q, write_q, miso_q;
  logic                capture;

  assign nss       = nss_sync[1];
  assign sclk      = sclk_sync[1];
  assign mosi      = mosi_sync[1];
  assign sclk_rise = sclk & ~sclk_d;
  assign sclk_fall = ~sclk & sclk_d;
  assign rx_next   = {rx_sr, mosi};

  // Synchronisers reset to 0 so an NSS still low after reset is not mistaken for a fresh fall.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      nss_sync  <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      nss_d     <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      nss_sync  <= {nss_sync[0], SPI_NSS_IN};
      sclk_sync <= {sclk_sync[0], SPI_SCLK_IN};
      mosi_sync <= {mosi_sync[0], SPI_MOSI_IN};
      nss_d     <= nss;
      sclk_d    <= sclk;
    end
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign capture = read_q;
  end else begin : g_latn
    logic [READ_LATENCY-1:0] rd_dly;
    always_ff @(posedge CLK_IN) begin
      if (RESET_IN) rd_dly <= '0;
      else          rd_dly <= (rd_dly << 1) | READ_LATENCY'(read_q);
    end
    assign capture = rd_dly[READ_LATENCY-1];
  end

`ifdef SPINNAKER_FPGAS_SPI_SLAVE_STATUS_EN
  logic [7:0] err_cnt, st_sr;
  logic       status_rd;
  assign status_rd = &SPI_ADDR_OUT;
`endif

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state              <= S_IDLE;
      bit_cnt            <= '0;
      rx_sr              <= '0;
      tx_sr              <= '0;
      is_read            <= 1'b0;
      is_write           <= 1'b0;
      read_q             <= 1'b0;
      write_q            <= 1'b0;
      miso_q             <= 1'b0;
      SPI_ADDR_OUT       <= '0;
      SPI_WRITE_DATA_OUT <= '0;
`ifdef SPINNAKER_FPGAS_SPI_SLAVE_STATUS_EN
      err_cnt            <= '0;
      st_sr              <= '0;
`endif
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      if (nss) begin
        state  <= S_IDLE;
        miso_q <= 1'b0;
`ifdef SPINNAKER_FPGAS_SPI_SLAVE_STATUS_EN
        if (is_write && (state == S_ADDR || state == S_DATA) && err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            bit_cnt  <= '0;
            is_read  <= 1'b0;
            is_write <= 1'b0;
            miso_q   <= 1'b0;
            state    <= nss_d ? S_CMD : S_IGNORE;
`ifdef SPINNAKER_FPGAS_SPI_SLAVE_STATUS_EN
            st_sr    <= err_cnt;
`endif
          end
          S_CMD: begin
`ifdef SPINNAKER_FPGAS_SPI_SLAVE_STATUS_EN
            if (sclk_fall) begin
              miso_q <= st_sr[7];
              st_sr  <= {st_sr[6:0], 1'b0};
            end
`else
            miso_q <= 1'b0;
`endif
            if (sclk_rise) begin
              rx_sr   <= rx_next[RX_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(7)) begin
                bit_cnt  <= '0;
                is_read  <= (rx_next[7:0] == CMD_READ);
                is_write <= (rx_next[7:0] == CMD_WRITE);
                if (rx_next[7:0] == CMD_READ || rx_next[7:0] == CMD_WRITE) begin
                  state <= S_ADDR;
                end else begin
                  state <= S_IGNORE;
`ifdef SPINNAKER_FPGAS_SPI_SLAVE_STATUS_EN
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
                end
              end
            end
          end
          S_ADDR: begin
            miso_q <= 1'b0;
            if (sclk_rise) begin
              rx_sr   <= rx_next[RX_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(SPI_ADDR_BITS - 1)) begin
                bit_cnt      <= '0;
                SPI_ADDR_OUT <= rx_next[SPI_ADDR_BITS-1:0];
                read_q       <= is_read;
                state        <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (is_read && sclk_fall) begin
              miso_q <= tx_sr[VAL_BITS-1];
              tx_sr  <= tx_sr << 1;
            end else if (!is_read) begin
              miso_q <= 1'b0;
            end
            if (sclk_rise) begin
              rx_sr   <= rx_next[RX_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(VAL_BITS - 1)) begin
                bit_cnt <= '0;
                miso_q  <= 1'b0;
                state   <= S_IGNORE;
                if (is_write) begin
                  SPI_WRITE_DATA_OUT <= rx_next[VAL_BITS-1:0];
                  write_q            <= 1'b1;
                end
              end
            end
          end
          S_IGNORE: miso_q <= 1'b0;
          default: begin
            state  <= S_IDLE;
            miso_q <= 1'b0;
          end
        endcase
      end
      // Half-period minimum guarantees the capture lands before the first MISO fall.
      if (capture) begin
`ifdef SPINNAKER_FPGAS_SPI_SLAVE_STATUS_EN
        if (status_rd) begin
          tx_sr   <= VAL_BITS'(err_cnt);
          err_cnt <= '0;
        end else begin
          tx_sr <= SPI_READ_VALUE_IN;
        end
`else
        tx_sr <= SPI_READ_VALUE_IN;
`endif
      end
    end
  end

  assign SPI_MISO_OUT  = miso_q;
  assign SPI_READ_OUT  = read_q & ~RESET_IN;
  assign SPI_WRITE_OUT = write_q & ~RESET_IN;

endmodule

// File: tb/tb_spinnaker_fpgas_spi_slave.sv
// Directed bench: three slaves (READ_LATENCY 1, 0, 3) share the SPI pins; each has a latency-exact read responder.
module tb_spinnaker_fpgas_spi_slave;

  localparam int HALF = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, nss, sclk, mosi;
  logic [2:0]  miso_o, rd_o, wr_o;
  logic [31:0] addr_o [3];
  logic [31:0] wdata_o [3];
  logic [31:0] rv_in [3];
  logic [31:0] rv_good;
  int          since [3] = '{100, 100, 100};

  int          rd_cnt [3] = '{0, 0, 0};
  int          wr_cnt [3] = '{0, 0, 0};
  int          rd0 [3], wr0 [3];
  logic [31:0] rd_addr [3], wr_addr [3], wr_data [3];
  int          both_cnt = 0;
  logic [71:0] miso_cap [3];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spinnaker_fpgas_spi_slave #(
      .SPI_ADDR_BITS(32),
      .VAL_BITS(32),
      .READ_LATENCY((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) dut (
      .CLK_IN(clk),
      .RESET_IN(rst),
      .SPI_NSS_IN(nss),
      .SPI_SCLK_IN(sclk),
      .SPI_MOSI_IN(mosi),
      .SPI_MISO_OUT(miso_o[g]),
      .SPI_ADDR_OUT(addr_o[g]),
      .SPI_READ_OUT(rd_o[g]),
      .SPI_WRITE_OUT(wr_o[g]),
      .SPI_WRITE_DATA_OUT(wdata_o[g]),
      .SPI_READ_VALUE_IN(rv_in[g])
    );
  end

  // Responder: the good value is only present exactly READ_LATENCY cycles after the strobe.
  always @(posedge clk)
    for (int g = 0; g < 3; g++)
      since[g] <= rd_o[g] ? 0 : ((since[g] < 100) ? since[g] + 1 : since[g]);

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      rv_in[g] = 32'hBAD0_BAD0;
      if ((rd_o[g] ? 0 : since[g] + 1) == lat_of(g)) rv_in[g] = rv_good;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rd_o[g]) begin
        rd_cnt[g]  = rd_cnt[g] + 1;
        rd_addr[g] = addr_o[g];
      end
      if (wr_o[g]) begin
        wr_cnt[g]  = wr_cnt[g] + 1;
        wr_addr[g] = addr_o[g];
        wr_data[g] = wdata_o[g];
      end
      if (rd_o[g] && wr_o[g]) both_cnt = both_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic snap();
    for (int g = 0; g < 3; g++) begin
      rd0[g] = rd_cnt[g];
      wr0[g] = wr_cnt[g];
    end
  endtask

  task automatic spi_xfer(input logic [71:0] frame, input int nbits, input int rst_at);
    for (int g = 0; g < 3; g++) miso_cap[g] = '0;
    @(negedge clk);
    nss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int n = 0; n < nbits; n++) begin
      mosi = frame[71-n];
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      for (int g = 0; g < 3; g++) miso_cap[g][71-n] = miso_o[g];
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    nss  = 1'b1;
    mosi = 1'b0;
    repeat (8 * HALF) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int exp_rd, input int exp_wr,
                             input logic [71:0] exp_miso);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("%s rd_cnt[%0d]", tag, g), 72'(rd_cnt[g] - rd0[g]), 72'(exp_rd));
      check_eq($sformatf("%s wr_cnt[%0d]", tag, g), 72'(wr_cnt[g] - wr0[g]), 72'(exp_wr));
      check_eq($sformatf("%s miso[%0d]", tag, g), miso_cap[g], exp_miso);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] val);
    rv_good = val;
    snap();
    spi_xfer({8'h03, addr, 32'h0}, 72, -1);
    check_frame(tag, 1, 0, {40'h0, val});
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("%s rd_addr[%0d]", tag, g), 72'(rd_addr[g]), 72'(addr));
      check_eq($sformatf("%s addr_hold[%0d]", tag, g), 72'(addr_o[g]), 72'(addr));
    end
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] val);
    snap();
    spi_xfer({8'h02, addr, val}, 72, -1);
    check_frame(tag, 0, 1, 72'h0);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("%s wr_addr[%0d]", tag, g), 72'(wr_addr[g]), 72'(addr));
      check_eq($sformatf("%s wr_data[%0d]", tag, g), 72'(wr_data[g]), 72'(val));
    end
  endtask

  initial begin
    rst = 1'b1; nss = 1'b1; sclk = 1'b0; mosi = 1'b0; rv_good = '0;
    repeat (5) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("rst addr[%0d]", g), 72'(addr_o[g]), 72'h0);
      check_eq($sformatf("rst wdata[%0d]", g), 72'(wdata_o[g]), 72'h0);
      check_eq($sformatf("rst miso[%0d]", g), 72'(miso_o[g]), 72'h0);
      check_eq($sformatf("rst rd[%0d]", g), 72'(rd_o[g]), 72'h0);
      check_eq($sformatf("rst wr[%0d]", g), 72'(wr_o[g]), 72'h0);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);

    do_write("write1", 32'h0002_0010, 32'hDEAD_BEEF);
    do_read("read1", 32'h0003_0004, 32'h1234_5678);

    // WRITE aborted after 20 data bits, then a full one to the same address.
    snap();
    spi_xfer({8'h02, 32'h0000_0008, 32'hFFFF_FFFF}, 60, -1);
    check_frame("abort", 0, 0, 72'h0);
    do_write("write2", 32'h0000_0008, 32'h0BAD_F00D);

    snap();
    spi_xfer({8'h5A, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 72, -1);
    check_frame("invalid", 0, 0, 72'h0);
    for (int g = 0; g < 3; g++)
      check_eq($sformatf("invalid addr_hold[%0d]", g), 72'(addr_o[g]), 72'h8);

    // One-cycle reset during the address phase with NSS held low.
    rv_good = 32'h7777_7777;
    snap();
    spi_xfer({8'h03, 32'h0004_0000, 32'h0}, 72, 18);
    check_frame("midrst", 0, 0, 72'h0);
    for (int g = 0; g < 3; g++)
      check_eq($sformatf("midrst addr[%0d]", g), 72'(addr_o[g]), 72'h0);
    do_read("read2", 32'h0001_0000, 32'hA5C3_0F96);

    do_read("b2b_rd", 32'h0000_0100, 32'h00FF_00FF);
    do_write("b2b_wr", 32'h0000_0200, 32'h1357_9BDF);

    check_eq("rd_wr_overlap", 72'(both_cnt), 72'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
